// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_e  : frame-position FSM encoding (IDLE must be 0)
//   PAR_EVEN/ODD: meaning of the PAR_TYP configuration bit
//   frame_cfg_t : per-frame configuration latched at frame start
package uart_rx_pkg;

   localparam int DEF_DATA_WIDTH = 8;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

   typedef struct packed {
      logic par_en;
      logic par_typ;
      logic stop_2;
   } frame_cfg_t;

endpackage

// File: rtl/uart_rx_err_counter.sv
// Saturating event counter with clear priority.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clears the count; wins over a coincident inc
//   inc      : count one event (ignored once the count is all-ones)
//   cnt      : current count
module uart_rx_err_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (inc && (cnt != {WIDTH{1'b1}}))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART receive-frame checker: tracks the frame position from mid-bit
// samples, deserialises the data field LSB-first and checks start, parity
// and stop bits.
//   CLK, RST            : clock, synchronous active-high reset
//   frame_start         : falling edge seen on RX, start bit begins
//   bit_valid           : sampled_bit holds the current bit value
//   PAR_EN/PAR_TYP/STOP_2 : frame format, latched at frame start
//   clr_err_cnt         : clears err_cnt
//   P_DATA              : last completed frame's data (bit 0 = first bit)
//   data_valid          : pulse, error-free frame on P_DATA
//   frame_done          : pulse, any frame completed
//   strt_glitch         : pulse, start bit sampled high, frame aborted
//   par_err / stp_err   : pulses alongside frame_done
//   busy                : FSM not idle
//   err_cnt             : saturating count of errored frames
module uart_rx_frame_check
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     frame_start,
   input  logic                     bit_valid,
   input  logic                     sampled_bit,
   input  logic                     PAR_EN,
   input  logic                     PAR_TYP,
   input  logic                     STOP_2,
   input  logic                     clr_err_cnt,
   output logic [DATA_WIDTH-1:0]    P_DATA,
   output logic                     data_valid,
   output logic                     frame_done,
   output logic                     strt_glitch,
   output logic                     par_err,
   output logic                     stp_err,
   output logic                     busy,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

   localparam int CNT_W = $clog2(DATA_WIDTH);

   rx_state_e             state, state_nxt;
   frame_cfg_t            cfg;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  stop_cnt;
   logic                  par_flag, stp_flag;

   logic cfg_load, shift_en, frame_end, glitch_ev;
   logic par_mismatch, stp_final, err_inc;

   // Parity is checked against the fully shifted data field.
   assign par_mismatch = sampled_bit != ((^shift_q) ^ (cfg.par_typ == PAR_ODD));
   // Stop flag including the bit being sampled now, so the final stop bit
   // is reflected in the same cycle the frame ends.
   assign stp_final    = stp_flag | ~sampled_bit;
   // One increment per errored frame, however many checks failed.
   assign err_inc      = glitch_ev | (frame_end & (par_flag | stp_final));

   always_ff @(posedge CLK) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cfg_load  = 1'b0;
      shift_en  = 1'b0;
      frame_end = 1'b0;
      glitch_ev = 1'b0;
      case (state)
         ST_IDLE: begin
            // bit_valid here is ignored, even alongside frame_start
            if (frame_start) begin
               state_nxt = ST_START;
               cfg_load  = 1'b1;
            end
         end
         ST_START: begin
            if (bit_valid) begin
               if (sampled_bit) begin
                  glitch_ev = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (bit_valid) begin
               shift_en = 1'b1;
               if (bit_cnt == CNT_W'(DATA_WIDTH-1))
                  state_nxt = cfg.par_en ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (bit_valid) state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (bit_valid && (!cfg.stop_2 || stop_cnt)) begin
               frame_end = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cfg         <= '0;
         shift_q     <= '0;
         bit_cnt     <= '0;
         stop_cnt    <= 1'b0;
         par_flag    <= 1'b0;
         stp_flag    <= 1'b0;
         P_DATA      <= '0;
         data_valid  <= 1'b0;
         frame_done  <= 1'b0;
         strt_glitch <= 1'b0;
         par_err     <= 1'b0;
         stp_err     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         strt_glitch <= glitch_ev;
         frame_done  <= frame_end;
         par_err     <= frame_end & par_flag;
         stp_err     <= frame_end & stp_final;
         data_valid  <= frame_end & ~(par_flag | stp_final);
         busy        <= (state_nxt != ST_IDLE);

         if (cfg_load) begin
            cfg      <= {PAR_EN, PAR_TYP, STOP_2};
            par_flag <= 1'b0;
            stp_flag <= 1'b0;
            stop_cnt <= 1'b0;
         end
         if (state == ST_START)
            bit_cnt <= '0;
         if (shift_en) begin
            // MSB-end insertion leaves the first received bit at bit 0
            shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (state == ST_PARITY && bit_valid) begin
            if (par_mismatch) par_flag <= 1'b1;
            stop_cnt <= 1'b0;
         end
         if (state == ST_STOP && bit_valid) begin
            if (!sampled_bit) stp_flag <= 1'b1;
            stop_cnt <= 1'b1;
         end
         // Errored frames still update P_DATA; glitches never do.
         if (frame_end)
            P_DATA <= shift_q;
      end
   end

   uart_rx_err_counter #(.WIDTH(ERR_CNT_WIDTH)) u_err_cnt (
      .clk (CLK),
      .rst (RST),
      .clr (clr_err_cnt),
      .inc (err_inc),
      .cnt (err_cnt)
   );

endmodule

// File: tb/tb_uart_rx_frame_check.sv
module tb_uart_rx_frame_check;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, clr, sb, pe, pt, s2;
   logic fs8, bv8, fs7, bv7;

   logic [7:0] pd8, ec8;
   logic       dv8, fd8, gl8, pe8, se8, bz8;
   logic [6:0] pd7;
   logic [7:0] ec7;
   logic       dv7, fd7, gl7, pe7, se7, bz7;

   uart_rx_frame_check #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(8)) dut8 (
      .CLK(clk), .RST(rst), .frame_start(fs8), .bit_valid(bv8), .sampled_bit(sb),
      .PAR_EN(pe), .PAR_TYP(pt), .STOP_2(s2), .clr_err_cnt(clr),
      .P_DATA(pd8), .data_valid(dv8), .frame_done(fd8), .strt_glitch(gl8),
      .par_err(pe8), .stp_err(se8), .busy(bz8), .err_cnt(ec8));

   uart_rx_frame_check #(.DATA_WIDTH(7), .ERR_CNT_WIDTH(8)) dut7 (
      .CLK(clk), .RST(rst), .frame_start(fs7), .bit_valid(bv7), .sampled_bit(sb),
      .PAR_EN(pe), .PAR_TYP(pt), .STOP_2(s2), .clr_err_cnt(clr),
      .P_DATA(pd7), .data_valid(dv7), .frame_done(fd7), .strt_glitch(gl7),
      .par_err(pe7), .stp_err(se7), .busy(bz7), .err_cnt(ec7));

   int n_checks = 0;
   int n_errs   = 0;
   int seen7    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      logic       gl;
      logic [7:0] pd;
      logic       dv, pe, se;
      logic [7:0] err;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] exp_err8 = 8'd0;
   logic [7:0] last_pd8 = 8'd0;

   task automatic push_exp(input logic gl, input logic [7:0] pd, input logic dv,
                           input logic pe_, input logic se_, input logic clr_hit);
      exp_t e;
      if (gl | pe_ | se_)
         exp_err8 = clr_hit ? 8'd0 : ((exp_err8 == 8'hFF) ? 8'hFF : exp_err8 + 8'd1);
      if (!gl) last_pd8 = pd;
      e.gl = gl; e.pd = gl ? last_pd8 : pd; e.dv = dv; e.pe = pe_; e.se = se_;
      e.err = exp_err8;
      sbq.push_back(e);
   endtask

   always @(negedge clk) begin
      if (fd8 || gl8) begin
         if (sbq.size() == 0) begin
            chk("unexpected_pulse", {30'd0, fd8, gl8}, 32'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("strt_glitch", gl8, e.gl);
            chk("frame_done",  fd8, !e.gl);
            chk("data_valid",  dv8, e.dv);
            chk("par_err",     pe8, e.pe);
            chk("stp_err",     se8, e.se);
            chk("P_DATA",      pd8, e.pd);
            chk("err_cnt",     ec8, e.err);
            chk("busy_at_end", bz8, 1'b0);
         end
      end
   end

   // 7-bit build only ever sees one clean 7O1 frame of 0x55
   always @(negedge clk) begin
      if (fd7 || gl7) begin
         seen7++;
         chk("w7_glitch",     gl7, 1'b0);
         chk("w7_data_valid", dv7, 1'b1);
         chk("w7_P_DATA",     pd7, 7'h55);
         chk("w7_par_err",    pe7, 1'b0);
         chk("w7_stp_err",    se7, 1'b0);
      end
   end

   // ---------------- stimulus ----------------
   logic clr_last = 1'b0;

   task automatic send_bit(input int sel, input logic b);
      sb = b;
      if (sel == 7) bv7 = 1'b1; else bv8 = 1'b1;
      @(posedge clk); #1;
      bv7 = 1'b0; bv8 = 1'b0; fs7 = 1'b0; fs8 = 1'b0; clr = 1'b0;
      @(posedge clk); #1;
   endtask

   // Config inputs are inverted right after frame start: the DUT must use
   // the values it latched.
   task automatic start_frame(input int sel, input logic pe_i, input logic pt_i, input logic s2_i);
      pe = pe_i; pt = pt_i; s2 = s2_i;
      if (sel == 7) fs7 = 1'b1; else fs8 = 1'b1;
      @(posedge clk); #1;
      fs7 = 1'b0; fs8 = 1'b0;
      pe = ~pe_i; pt = ~pt_i; s2 = ~s2_i;
   endtask

   task automatic send_body(input int sel, input int nbits, input logic stb, input logic [8:0] data,
                            input logic par_en_i, input logic parb, input logic s2_i,
                            input logic s1b, input logic s2b, input logic mid_fs);
      send_bit(sel, stb);
      if (stb) return;
      for (int i = 0; i < nbits; i++) begin
         if (mid_fs && i == 3) fs8 = 1'b1;
         send_bit(sel, data[i]);
      end
      if (par_en_i) send_bit(sel, parb);
      if (clr_last && !s2_i) clr = 1'b1;
      send_bit(sel, s1b);
      if (s2_i) begin
         if (clr_last) clr = 1'b1;
         send_bit(sel, s2b);
      end
   endtask

   typedef struct {
      logic       pe, pt, s2, stb, parb, s1b, s2b;
      logic [7:0] data;
      logic [7:0] exp_pd;
      logic       exp_dv, exp_pe, exp_se, exp_gl;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      //          pe  pt  s2  stb parb s1b s2b data    exp_pd  dv  pe  se  gl
      vecs[0] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,8'hA5, 8'hA5, 1'b1,1'b0,1'b0,1'b0}; // 8N1 clean
      vecs[1] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,8'h00, 8'hA5, 1'b0,1'b0,1'b0,1'b1}; // start glitch
      vecs[2] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,8'h03, 8'h03, 1'b0,1'b1,1'b0,1'b0}; // 8E1 bad parity
      vecs[3] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h3C, 8'h3C, 1'b0,1'b0,1'b1,1'b0}; // 8N2 2nd stop low
      vecs[4] = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,8'h00, 8'h00, 1'b1,1'b0,1'b0,1'b0}; // 8O2 clean
      vecs[5] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'hF0, 8'hF0, 1'b0,1'b0,1'b1,1'b0}; // 8N2 1st stop low
      vecs[6] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,8'hFF, 8'hFF, 1'b0,1'b1,1'b1,1'b0}; // both errors
      vecs[7] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,8'h80, 8'h80, 1'b1,1'b0,1'b0,1'b0}; // 8O1 clean
      vecs[8] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,8'h7E, 8'h7E, 1'b1,1'b0,1'b0,1'b0}; // 8E2 clean

      rst = 1'b1; clr = 1'b0; sb = 1'b1; pe = 1'b0; pt = 1'b0; s2 = 1'b0;
      fs8 = 1'b0; bv8 = 1'b0; fs7 = 1'b0; bv7 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_P_DATA", pd8, 8'h00);
      chk("rst_pulses", {dv8, fd8, gl8, pe8, se8}, 5'b0);
      chk("rst_busy",   bz8, 1'b0);
      chk("rst_err_cnt", ec8, 8'h00);

      for (int v = 0; v < 9; v++) begin
         push_exp(vecs[v].exp_gl, vecs[v].exp_pd, vecs[v].exp_dv, vecs[v].exp_pe, vecs[v].exp_se, 1'b0);
         start_frame(8, vecs[v].pe, vecs[v].pt, vecs[v].s2);
         @(negedge clk);
         chk("busy_in_frame", bz8, 1'b1);
         send_body(8, 8, vecs[v].stb, {1'b0, vecs[v].data}, vecs[v].pe, vecs[v].parb,
                   vecs[v].s2, vecs[v].s1b, vecs[v].s2b, 1'b0);
         repeat (3) @(posedge clk);
         #1;
      end

      // frame_start and bit_valid (high) together in IDLE: bit is ignored
      push_exp(1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
      pe = 1'b0; pt = 1'b0; s2 = 1'b0;
      fs8 = 1'b1; bv8 = 1'b1; sb = 1'b1;
      @(posedge clk); #1 fs8 = 1'b0; bv8 = 1'b0;
      send_body(8, 8, 1'b0, 9'h05A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (3) @(posedge clk); #1;

      // frame_start mid-frame is ignored
      push_exp(1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
      start_frame(8, 1'b0, 1'b0, 1'b0);
      send_body(8, 8, 1'b0, 9'h0C3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      repeat (3) @(posedge clk); #1;

      // reset during DATA bit 4 abandons the frame silently
      start_frame(8, 1'b0, 1'b0, 1'b0);
      send_bit(8, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(8, 1'b1);
      rst = 1'b1; sb = 1'b0; bv8 = 1'b1;
      @(posedge clk); #1 rst = 1'b0; bv8 = 1'b0;
      exp_err8 = 8'd0; last_pd8 = 8'd0;
      @(negedge clk);
      chk("midrst_P_DATA", pd8, 8'h00);
      chk("midrst_pulses", {dv8, fd8, gl8, pe8, se8}, 5'b0);
      chk("midrst_busy",   bz8, 1'b0);
      chk("midrst_err_cnt", ec8, 8'h00);
      for (int i = 0; i < 4; i++) send_bit(8, 1'b1);
      repeat (3) @(posedge clk); #1;

      // DATA_WIDTH=7 build, 7O1 0x55 with correct parity 1
      start_frame(7, 1'b1, 1'b1, 1'b0);
      send_body(7, 7, 1'b0, 9'h055, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (3) @(posedge clk); #1;

      // 256 errored frames saturate the counter
      for (int n = 0; n < 256; n++) begin
         push_exp(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
         start_frame(8, 1'b0, 1'b0, 1'b0);
         send_body(8, 8, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
         @(posedge clk); #1;
      end
      repeat (2) @(posedge clk); #1;
      chk("err_cnt_saturated", ec8, 8'hFF);

      // clear coinciding with an errored frame_done: clear wins
      clr_last = 1'b1;
      push_exp(1'b0, 8'h99, 1'b0, 1'b0, 1'b1, 1'b1);
      start_frame(8, 1'b0, 1'b0, 1'b0);
      send_body(8, 8, 1'b0, 9'h099, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      clr_last = 1'b0;
      repeat (3) @(posedge clk); #1;

      // counting resumes from zero
      push_exp(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      start_frame(8, 1'b0, 1'b0, 1'b0);
      send_body(8, 8, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (4) @(posedge clk); #1;

      chk("scoreboard_drained", sbq.size(), 32'd0);
      chk("w7_frames_seen", seen7, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
